// File: rtl/pwm_fade_scheduler_if.sv
// Fade command channel for pwm_fade_scheduler.
// A command transfers on a cycle where cmd_valid and cmd_ready are both high.
interface pwm_fade_scheduler_if #(
  parameter int LW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_chan;
  logic [LW-1:0] cmd_target;
  logic [3:0]    cmd_step;

  // Command source side
  modport master (
    output cmd_valid,
    output cmd_chan,
    output cmd_target,
    output cmd_step,
    input  cmd_ready
  );

  // Scheduler side
  modport slave (
    input  cmd_valid,
    input  cmd_chan,
    input  cmd_target,
    input  cmd_step,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_fade_scheduler.sv
// pwm_fade_scheduler: walks every PWM channel once per frame_tick and moves
// its current level one step toward its commanded target, emitting one
// registered level write per channel that changed.
// Optional feature: define PWM_FADE_READBACK_EN to build the rd_chan/rd_level
// current-level readback mux; otherwise rd_level is tied to 0.
module pwm_fade_scheduler #(
  parameter int NUM_CH = 7,
  parameter int LW     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  pwm_fade_scheduler_if.slave  cmd,
  output logic                 level_wr_en,
  output logic [2:0]           level_wr_chan,
  output logic [LW-1:0]        level_wr_data,
  output logic                 settled,
  output logic                 bad_chan,
  output logic                 overrun,
  input  logic [2:0]           rd_chan,
  output logic [LW-1:0]        rd_level
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);
  localparam logic [2:0] LAST_IDX = 3'(NUM_CH - 1);

  // Control state
  state_t        state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic          pending_reg, pending_next;
  logic          overrun_reg, overrun_next;

  // Registered outputs
  logic          wr_en_reg, wr_en_next;
  logic [2:0]    wr_chan_reg, wr_chan_next;
  logic [LW-1:0] wr_data_reg, wr_data_next;
  logic          bad_chan_reg, bad_chan_next;
  logic          settled_reg, settled_next;

  // Per-channel fade state
  logic [LW-1:0] current_reg [NUM_CH];
  logic [LW-1:0] current_next[NUM_CH];
  logic [LW-1:0] target_reg  [NUM_CH];
  logic [LW-1:0] target_next [NUM_CH];
  logic [3:0]    step_reg    [NUM_CH];
  logic [3:0]    step_next   [NUM_CH];

  // Handshake
  logic cmd_ready_int;
  logic cmd_fire;
  logic chan_ok;

  // Channel under scan
  logic [LW-1:0] cur_sel;
  logic [LW-1:0] tgt_sel;
  logic [3:0]    stp_sel;
  logic [LW:0]   up_sum;
  logic [LW:0]   down_diff;
  logic [LW-1:0] ch_next;
  logic          ch_differs;

  logic [NUM_CH-1:0] eq_vec;

  // Commands are only taken while idle so targets never move under a scan.
  assign cmd_ready_int = (state_reg == IDLE) && !reset;
  assign cmd.cmd_ready = cmd_ready_int;
  assign cmd_fire      = cmd.cmd_valid && cmd_ready_int;
  assign chan_ok       = {1'b0, cmd.cmd_chan} < NUM_CH_W;

  // Step the indexed channel toward its target; the extra top bit keeps
  // overshoot and underflow visible so the result clamps instead of wrapping.
  always_comb begin
    cur_sel    = current_reg[idx_reg];
    tgt_sel    = target_reg[idx_reg];
    stp_sel    = step_reg[idx_reg];
    up_sum     = {1'b0, cur_sel} + {{(LW-3){1'b0}}, stp_sel};
    down_diff  = {1'b0, cur_sel} - {{(LW-3){1'b0}}, stp_sel};
    ch_differs = (cur_sel != tgt_sel);
    ch_next    = tgt_sel;
    if (stp_sel == 4'd0) begin
      ch_next = tgt_sel;
    end else if (cur_sel < tgt_sel) begin
      ch_next = (up_sum >= {1'b0, tgt_sel}) ? tgt_sel : up_sum[LW-1:0];
    end else if (down_diff[LW] || (down_diff[LW-1:0] <= tgt_sel)) begin
      ch_next = tgt_sel;
    end else begin
      ch_next = down_diff[LW-1:0];
    end
  end

  // Next-state of the per-channel registers: command writes target/step,
  // the scan writes current for the channel being processed.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      current_next[i] = current_reg[i];
      target_next[i]  = target_reg[i];
      step_next[i]    = step_reg[i];
      if (cmd_fire && (cmd.cmd_chan == 3'(i))) begin
        target_next[i] = cmd.cmd_target;
        step_next[i]   = cmd.cmd_step;
      end
      if ((state_reg == SCAN) && ch_differs && (idx_reg == 3'(i))) begin
        current_next[i] = ch_next;
      end
    end
  end

  // Per-channel "at target" flags, taken from next-state so settled lines up
  // with the write that completes a fade.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_eq
      assign eq_vec[gi] = (current_next[gi] == target_next[gi]);
    end
  endgenerate

  // Scan sequencing, tick pending/overrun tracking and output strobes.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    pending_next  = pending_reg;
    overrun_next  = overrun_reg;
    wr_en_next    = 1'b0;
    wr_chan_next  = wr_chan_reg;
    wr_data_next  = wr_data_reg;
    bad_chan_next = cmd_fire && !chan_ok;
    settled_next  = &eq_vec;

    case (state_reg)
      IDLE: begin
        idx_next = 3'd0;
        if (frame_tick) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (ch_differs) begin
          wr_en_next   = 1'b1;
          wr_chan_next = idx_reg;
          wr_data_next = ch_next;
        end
        if (idx_reg == LAST_IDX) begin
          idx_next = 3'd0;
          if (pending_reg || frame_tick) begin
            // Restart immediately; a tick landing alongside a pending one
            // becomes the new pending tick.
            state_next   = SCAN;
            pending_next = pending_reg && frame_tick;
          end else begin
            state_next = IDLE;
          end
        end else begin
          idx_next = idx_reg + 3'd1;
          if (frame_tick) begin
            if (pending_reg) begin
              overrun_next = 1'b1;
            end else begin
              pending_next = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 3'd0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= 3'd0;
      pending_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_chan_reg  <= 3'd0;
      wr_data_reg  <= '0;
      bad_chan_reg <= 1'b0;
      settled_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      pending_reg  <= pending_next;
      overrun_reg  <= overrun_next;
      wr_en_reg    <= wr_en_next;
      wr_chan_reg  <= wr_chan_next;
      wr_data_reg  <= wr_data_next;
      bad_chan_reg <= bad_chan_next;
      settled_reg  <= settled_next;
    end
  end

  // Per-channel current/target/step storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        current_reg[i] <= '0;
        target_reg[i]  <= '0;
        step_reg[i]    <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        current_reg[i] <= current_next[i];
        target_reg[i]  <= target_next[i];
        step_reg[i]    <= step_next[i];
      end
    end
  end

  assign level_wr_en   = wr_en_reg;
  assign level_wr_chan = wr_chan_reg;
  assign level_wr_data = wr_data_reg;
  assign settled       = settled_reg;
  assign bad_chan      = bad_chan_reg;
  assign overrun       = overrun_reg;

`ifdef PWM_FADE_READBACK_EN
  // Combinational readback of a channel's current level; out-of-range reads 0.
  always_comb begin
    rd_level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_chan == 3'(i)) begin
        rd_level = current_reg[i];
      end
    end
  end
`else
  logic unused_rd_chan;
  assign unused_rd_chan = ^rd_chan;
  assign rd_level       = '0;
`endif

endmodule
